i2c_shift_reg: RTL and testbench
================================

Name: i2c_shift_reg

Overview:
- Parametrised serial/parallel shift engine for the I2C slave datapath; successor to the fixed 4-bit serial-in shifter.
- Shifts one bit per strobe in either bit order and counts bits to word boundaries.
- Captures each completed word into a holding register with a valid/ack handshake and flags overrun.
- Supports parallel load for transmit, so one instance serves both the RX path (address/data byte) and the TX path (read data).

Parameters:
- WIDTH, 8, word length in bits (>= 2)
- MSB_FIRST, 1, 1 = MSB shifted first (I2C order), 0 = LSB first
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: counter, shift register, flags to reset values
- shift_en  in  1  single-cycle strobe: shift one bit (caller qualifies with SCL edge)
- serial_in  in  1  bit sampled on shift_en
- load  in  1  parallel load of load_data into shift register; counter to 0
- load_data  in  WIDTH  transmit word
- serial_out  out  1  bit currently presented (MSB or LSB of shift register per MSB_FIRST)
- shift_q  out  WIDTH  live shift register contents
- bit_cnt  out  CNT_W  bits shifted in current word, 0..WIDTH
- word_done  out  1  one-cycle pulse, the cycle after the WIDTH-th shift
- rx_data  out  WIDTH  holding register, captured at word completion
- rx_valid  out  1  rx_data valid; held until rx_ack
- rx_ack  in  1  consumer acknowledge, clears rx_valid
- overrun  out  1  sticky: word completed while rx_valid still set

Behaviour:
- Reset (rst_n low, async): shift_q = 0, bit_cnt = 0, rx_data = 0, rx_valid = 0, overrun = 0, word_done = 0; serial_out therefore 0. Mid-word reset discards the partial word.
- Priority per cycle: clear > load > shift_en. Lower-priority requests in the same cycle are dropped, not deferred.
- clear: behaves as reset, except it occurs on the clock edge.
- load: shift_q <= load_data; bit_cnt <= 0; rx_valid, rx_data and overrun are unchanged.
- Shift with MSB_FIRST = 1: shift_q <= {shift_q[WIDTH-2:0], serial_in}; serial_out = shift_q[WIDTH-1].
- Shift with MSB_FIRST = 0: shift_q <= {serial_in, shift_q[WIDTH-1:1]}; serial_out = shift_q[0].
- All state uses nonblocking assignment; serial_out is combinational from shift_q.
- Counter (FSM IDLE / ACTIVE / FULL encoded by bit_cnt):
  - Shift with bit_cnt < WIDTH increments bit_cnt.
  - Shift with bit_cnt == WIDTH: wrap to 1 (new word starts; no explicit clear needed).
  - Counter never exceeds WIDTH.
- Word completion: shift taking bit_cnt from WIDTH-1 (or from WIDTH via wrap with WIDTH == 1, excluded by WIDTH >= 2) to WIDTH:
  - Next cycle: word_done = 1 for exactly one cycle.
  - rx_data = new shift_q, rx_valid = 1.
  - If rx_valid was already 1 and no rx_ack arrives in the completion cycle: overrun <= 1 and rx_data is still overwritten (newest wins).
- Handshake:
  - rx_ack with rx_valid = 1 clears rx_valid next cycle.
  - rx_ack in the same cycle as a completing shift: ack consumes the old word; rx_valid stays 1 for the new word; no overrun.
  - rx_ack with rx_valid = 0 is ignored.
- overrun: cleared only by clear or reset.
- rx_data: stable between completions regardless of further shifting or load.

Decomposition:
- Package i2c_pkg: bit-order enum (MSB_FIRST_E / LSB_FIRST_E), default I2C_WORD_W = 8.
- Sub-module i2c_bit_counter (WIDTH-bounded wrap counter with terminal-count pulse), instantiated once.
- Datapath and handshake stay in i2c_shift_reg.

Test Plan:
- Reset mid-word: 3 shifts, assert rst_n low asynchronously -> all outputs 0 immediately, bit_cnt = 0, no word_done.
- MSB_FIRST = 1, WIDTH = 8: shift serial 1,0,1,0,0,1,0,1 -> word_done one cycle after the 8th shift; rx_data = 8'hA5; rx_valid = 1; bit_cnt = 8.
- MSB_FIRST = 0, same bit sequence -> rx_data = 8'hA5 bit-reversed = 8'hA5 palindrome check fails; use 1,1,0,0,0,0,0,0 -> rx_data = 8'h03.
- TX: load 8'h3C then 8 shifts with serial_in = 0 -> serial_out sequence 0,0,1,1,1,1,0,0 (MSB first); bit_cnt = 8.
- Overrun: complete 8'h11, no ack, complete 8'h22 -> overrun = 1, rx_data = 8'h22. Repeat with rx_ack in the completion cycle -> overrun stays 0, rx_valid = 1.
- Priority: assert clear, load (8'hFF) and shift_en together at bit_cnt = 5 -> shift_q = 0, bit_cnt = 0, flags 0. load + shift_en together -> shift_q = 8'hFF, bit_cnt = 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave datapath.
//   bit_order_e : serial bit order of the shift engine
//   I2C_WORD_W  : default word length (one I2C byte)
package i2c_pkg;

    localparam int unsigned I2C_WORD_W = 8;

    typedef enum logic {
        LSB_FIRST_E = 1'b0,
        MSB_FIRST_E = 1'b1
    } bit_order_e;

endpackage : i2c_pkg

// File: rtl/i2c_bit_counter.sv
// Bit counter bounded to WIDTH with wrap-to-1 and a terminal-count strobe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous return to 0 (wins over step)
//   step       : count one bit
//   cnt        : bits counted in the current word, 0..WIDTH
//   done_c     : combinational, high in the cycle whose step takes cnt to WIDTH
module i2c_bit_counter
    import i2c_pkg::*;
#(
    parameter int unsigned WIDTH = I2C_WORD_W,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_nxt;

    // Next count: a step on a full word starts the next word at 1.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (step) begin
            if (cnt == CNT_W'(WIDTH)) begin
                cnt_nxt = CNT_W'(1);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    assign done_c = step && !clr && (cnt == CNT_W'(WIDTH - 1));

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule : i2c_bit_counter

// File: rtl/i2c_shift_reg.sv
// Serial/parallel shift engine for the I2C slave datapath (RX and TX).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous flush of all state
//   shift_en          : shift one bit (serial_in) this cycle
//   load, load_data   : parallel load for transmit, counter to 0
//   serial_out        : bit currently presented on the line side
//   shift_q, bit_cnt  : live shift register and bit count
//   word_done         : one-cycle pulse after the completing shift
//   rx_data, rx_valid : completed word holding register and its valid flag
//   rx_ack            : consumer acknowledge of rx_data
//   overrun           : sticky, a word completed while rx_valid was pending
// Priority each cycle: clear > load > shift_en.
module i2c_shift_reg
    import i2c_pkg::*;
#(
    parameter int unsigned WIDTH     = I2C_WORD_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic [WIDTH-1:0] shift_q,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun
);

    localparam bit_order_e ORDER = MSB_FIRST ? MSB_FIRST_E : LSB_FIRST_E;

    logic [WIDTH-1:0] shift_nxt_c;
    logic             cnt_clr_c;
    logic             done_c;

    assign cnt_clr_c = clear || load;

    // Shift register value after one shift in the configured bit order.
    always_comb begin
        shift_nxt_c = shift_q;
        if (ORDER == MSB_FIRST_E) begin
            shift_nxt_c = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            shift_nxt_c = {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    assign serial_out = (ORDER == MSB_FIRST_E) ? shift_q[WIDTH-1] : shift_q[0];

    i2c_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr_c),
        .step   (shift_en),
        .cnt    (bit_cnt),
        .done_c (done_c)
    );

    // Datapath, holding register and handshake flags.
    // done_c is already gated by clear/load inside the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            word_done <= 1'b0;
        end else if (clear) begin
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load) begin
                shift_q <= load_data;
            end else if (shift_en) begin
                shift_q <= shift_nxt_c;
            end

            if (done_c) begin
                // Newest word always wins; an ack this cycle consumes the old one.
                rx_data   <= shift_nxt_c;
                rx_valid  <= 1'b1;
                word_done <= 1'b1;
                if (rx_valid && !rx_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule : i2c_shift_reg

// File: tb/tb_i2c_shift_reg.sv
module tb_i2c_shift_reg;

    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       shift_en;
    logic       serial_in;
    logic       load;
    logic [7:0] load_data;
    logic       rx_ack;

    logic       serial_out_m, serial_out_l;
    logic [7:0] shift_q_m, shift_q_l;
    logic [3:0] bit_cnt_m, bit_cnt_l;
    logic       word_done_m, word_done_l;
    logic [7:0] rx_data_m, rx_data_l;
    logic       rx_valid_m, rx_valid_l;
    logic       overrun_m, overrun_l;

    int checks = 0;
    int errors = 0;

    exp_t       sb_q[$];
    logic [7:0] m_msb;
    logic [7:0] m_lsb;
    int         m_cnt;

    always #5 clk = ~clk;

    i2c_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .load(load), .load_data(load_data),
        .serial_out(serial_out_m), .shift_q(shift_q_m), .bit_cnt(bit_cnt_m),
        .word_done(word_done_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
        .rx_ack(rx_ack), .overrun(overrun_m)
    );

    i2c_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .load(load), .load_data(load_data),
        .serial_out(serial_out_l), .shift_q(shift_q_l), .bit_cnt(bit_cnt_l),
        .word_done(word_done_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
        .rx_ack(rx_ack), .overrun(overrun_l)
    );

    // Scoreboard monitor: every word_done pops one expected word pair.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n && (word_done_m || word_done_l)) begin
            checks++;
            if (word_done_m !== word_done_l) begin
                errors++;
                $display("FAIL word_done_pair msb=%b lsb=%b required equal", word_done_m, word_done_l);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word_done rx_m=%h rx_l=%h required none", rx_data_m, rx_data_l);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (rx_data_m !== e.msb) begin
                    errors++;
                    $display("FAIL rx_data_msb got %h required %h", rx_data_m, e.msb);
                end
                checks++;
                if (rx_data_l !== e.lsb) begin
                    errors++;
                    $display("FAIL rx_data_lsb got %h required %h", rx_data_l, e.lsb);
                end
                checks++;
                if (rx_valid_m !== 1'b1 || rx_valid_l !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_valid_on_done got %b/%b required 1/1", rx_valid_m, rx_valid_l);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_msb = 8'h00;
        m_lsb = 8'h00;
        m_cnt = 0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({shift_q_m, shift_q_l, bit_cnt_m, bit_cnt_l, rx_data_m, rx_data_l} !== '0 ||
            {rx_valid_m, rx_valid_l, overrun_m, overrun_l, word_done_m, word_done_l,
             serial_out_m, serial_out_l} !== '0) begin
            errors++;
            $display("FAIL %s q=%h/%h cnt=%0d/%0d rx=%h/%h v=%b/%b ovr=%b/%b wd=%b/%b so=%b/%b required all 0",
                     name, shift_q_m, shift_q_l, bit_cnt_m, bit_cnt_l, rx_data_m, rx_data_l,
                     rx_valid_m, rx_valid_l, overrun_m, overrun_l, word_done_m, word_done_l,
                     serial_out_m, serial_out_l);
        end
    endtask

    task automatic do_shift(input logic b, input logic ack);
        checks++;
        if (serial_out_m !== m_msb[7] || serial_out_l !== m_lsb[0]) begin
            errors++;
            $display("FAIL serial_out got %b/%b required %b/%b", serial_out_m, serial_out_l, m_msb[7], m_lsb[0]);
        end
        shift_en  = 1'b1;
        serial_in = b;
        rx_ack    = ack;
        m_msb = {m_msb[6:0], b};
        m_lsb = {b, m_lsb[7:1]};
        m_cnt = (m_cnt == 8) ? 1 : m_cnt + 1;
        if (m_cnt == 8) sb_q.push_back('{msb: m_msb, lsb: m_lsb});
        tick();
        shift_en = 1'b0;
        rx_ack   = 1'b0;
        checks++;
        if (bit_cnt_m !== 4'(m_cnt) || bit_cnt_l !== 4'(m_cnt) ||
            shift_q_m !== m_msb || shift_q_l !== m_lsb) begin
            errors++;
            $display("FAIL shift_state cnt=%0d/%0d q=%h/%h required cnt=%0d q=%h/%h",
                     bit_cnt_m, bit_cnt_l, shift_q_m, shift_q_l, m_cnt, m_msb, m_lsb);
        end
    endtask

    task automatic shift_byte_msb(input logic [7:0] v, input logic ack_last);
        for (int i = 7; i >= 0; i--) do_shift(v[i], (i == 0) ? ack_last : 1'b0);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        checks++;
        if (rx_valid_m !== 1'b0 || rx_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears_valid got %b/%b required 0/0", rx_valid_m, rx_valid_l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_zero("reset_initial");
        tick();
        rst_n = 1'b1;
        model_zero();
        tick();
        do_shift(1'b1, 1'b0);
        do_shift(1'b1, 1'b0);
        do_shift(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async_midword");
        model_zero();
        tick();
        rst_n = 1'b1;
        tick();
        check_zero("reset_release");
    endtask

    task automatic test_msb_rx();
        logic [7:0] pat;
        pat = 8'hA5;
        shift_byte_msb(pat, 1'b0);
        checks++;
        if (word_done_m !== 1'b1 || rx_data_m !== 8'hA5 || rx_data_l !== 8'hA5 ||
            rx_valid_m !== 1'b1 || bit_cnt_m !== 4'd8) begin
            errors++;
            $display("FAIL msb_rx wd=%b rx=%h/%h v=%b cnt=%0d required 1 a5/a5 1 8",
                     word_done_m, rx_data_m, rx_data_l, rx_valid_m, bit_cnt_m);
        end
        tick();
        checks++;
        if (word_done_m !== 1'b0 || word_done_l !== 1'b0 || rx_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL word_done_one_cycle wd=%b/%b v=%b required 0/0 1", word_done_m, word_done_l, rx_valid_m);
        end
        do_ack();
    endtask

    task automatic test_lsb_rx();
        logic [7:0] bits;
        bits = 8'b1100_0000;
        for (int i = 7; i >= 0; i--) do_shift(bits[i], 1'b0);
        checks++;
        if (rx_data_l !== 8'h03 || rx_data_m !== 8'hC0 || rx_valid_l !== 1'b1) begin
            errors++;
            $display("FAIL lsb_rx rx_l=%h rx_m=%h v=%b required 03 c0 1", rx_data_l, rx_data_m, rx_valid_l);
        end
        do_ack();
    endtask

    task automatic test_tx_load();
        logic [7:0] so_seq;
        logic [7:0] so_got_m;
        logic [7:0] so_got_l;
        so_seq = 8'b0011_1100;
        load      = 1'b1;
        load_data = 8'h3C;
        tick();
        load = 1'b0;
        m_msb = 8'h3C;
        m_lsb = 8'h3C;
        m_cnt = 0;
        checks++;
        if (shift_q_m !== 8'h3C || bit_cnt_m !== 4'd0 || bit_cnt_l !== 4'd0 || rx_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL tx_load q=%h cnt=%0d/%0d v=%b required 3c 0/0 0", shift_q_m, bit_cnt_m, bit_cnt_l, rx_valid_m);
        end
        for (int i = 7; i >= 0; i--) begin
            so_got_m[i] = serial_out_m;
            so_got_l[i] = serial_out_l;
            do_shift(1'b0, 1'b0);
        end
        checks++;
        if (so_got_m !== so_seq || so_got_l !== so_seq || bit_cnt_m !== 4'd8) begin
            errors++;
            $display("FAIL tx_serial_seq got %b/%b cnt=%0d required %b 8", so_got_m, so_got_l, bit_cnt_m, so_seq);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        shift_byte_msb(8'h11, 1'b0);
        tick();
        shift_byte_msb(8'h22, 1'b0);
        checks++;
        if (overrun_m !== 1'b1 || overrun_l !== 1'b1 || rx_data_m !== 8'h22 || rx_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set ovr=%b/%b rx=%h v=%b required 1/1 22 1", overrun_m, overrun_l, rx_data_m, rx_valid_m);
        end
        do_ack();
        checks++;
        if (overrun_m !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b required 1", overrun_m);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check_zero("clear_flush");
        shift_byte_msb(8'h11, 1'b0);
        tick();
        shift_byte_msb(8'h22, 1'b1);
        checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0 || rx_valid_m !== 1'b1 || rx_data_m !== 8'h22) begin
            errors++;
            $display("FAIL ack_on_completion ovr=%b/%b v=%b rx=%h required 0/0 1 22", overrun_m, overrun_l, rx_valid_m, rx_data_m);
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) do_shift(1'b1, 1'b0);
        clear     = 1'b1;
        load      = 1'b1;
        load_data = 8'hFF;
        shift_en  = 1'b1;
        serial_in = 1'b1;
        tick();
        clear    = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        model_zero();
        check_zero("prio_clear");
        for (int i = 0; i < 3; i++) do_shift(1'b0, 1'b0);
        load      = 1'b1;
        load_data = 8'hFF;
        shift_en  = 1'b1;
        serial_in = 1'b0;
        tick();
        load     = 1'b0;
        shift_en = 1'b0;
        m_msb = 8'hFF;
        m_lsb = 8'hFF;
        m_cnt = 0;
        checks++;
        if (shift_q_m !== 8'hFF || shift_q_l !== 8'hFF || bit_cnt_m !== 4'd0 || word_done_m !== 1'b0) begin
            errors++;
            $display("FAIL prio_load q=%h/%h cnt=%0d wd=%b required ff/ff 0 0", shift_q_m, shift_q_l, bit_cnt_m, word_done_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int w = 0; w < 4; w++) begin
            v = 8'($urandom);
            for (int i = 7; i >= 0; i--) do_shift(v[i], (w != 0 && i == 7) ? 1'b1 : 1'b0);
        end
        do_ack();
        checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_overrun got %b/%b required 0/0", overrun_m, overrun_l);
        end
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained left %0d required 0", sb_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        shift_en  = 1'b0;
        serial_in = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        rx_ack    = 1'b0;
        model_zero();
        test_reset();
        test_msb_rx();
        test_lsb_rx();
        test_tx_load();
        test_overrun();
        test_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_i2c_shift_reg
